// File: rtl/mem_access_ctrl_if.sv
// CPU-side bus of mem_access_ctrl: request channel, write-beat channel and
// read-response channel.
//   master : CPU side (drives req_*, wd_valid/wd_data, resp_ready)
//   slave  : controller side (drives req_ready, wd_ready, resp_*)
interface mem_access_ctrl_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 3;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;

    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;

    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_last;

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wd_valid, wd_data,
        output resp_ready,
        input  req_ready, wd_ready,
        input  resp_valid, resp_data, resp_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wd_valid, wd_data,
        input  resp_ready,
        output req_ready, wd_ready,
        output resp_valid, resp_data, resp_last
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Burst memory access controller: accepts a CPU read/write burst request,
// range-checks it against the attached memory, then streams write beats to
// the memory or fetches read beats one at a time into a held response.
//   clk, reset      : clock, asynchronous active-low reset
//   bus (slave)     : CPU request / write-beat / read-response channels
//   err             : one-cycle pulse when a request is rejected
//   busy            : controller not idle
//   address, data   : memory word address / write data
//   memW, memR      : memory write strobe / read enable (combinational read)
//   readData        : memory read data
module mem_access_ctrl #(
    parameter int unsigned SIZE      = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_ctrl_if.slave    bus,
    output logic                err,
    output logic                busy,
    output logic [31:0]         address,
    output logic [31:0]         data,
    output logic                memW,
    output logic                memR,
    input  logic [31:0]         readData
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [DW-1:0] resp_data_q, resp_data_d;

    logic          last_beat;
    logic [AW:0]   end_addr;
    logic          bad_req;

    // Last word touched by the request, widened so a top-of-space start cannot wrap.
    assign end_addr  = (AW+1)'(bus.req_addr) + (AW+1)'(bus.req_len) - (AW+1)'(1);
    assign bad_req   = (bus.req_len == '0)
                     || (32'(bus.req_len) > MAX_BURST)
                     || (end_addr >= (AW+1)'(SIZE));
    assign last_beat = (beat_q == LW'(len_q - LW'(1)));

    assign bus.resp_data = resp_data_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        len_d          = len_q;
        beat_d         = beat_q;
        resp_data_d    = resp_data_q;
        bus.req_ready  = 1'b0;
        bus.wd_ready   = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_last  = 1'b0;
        err            = 1'b0;
        busy           = 1'b0;
        address        = '0;
        data           = '0;
        memW           = 1'b0;
        memR           = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    cur_addr_d = bus.req_addr;
                    len_d      = bus.req_len;
                    beat_d     = '0;
                    if (bad_req)            state_d = ERR;
                    else if (bus.req_write) state_d = WRITE;
                    else                    state_d = READ;
                end
            end
            WRITE: begin
                busy         = 1'b1;
                bus.wd_ready = 1'b1;
                memW         = bus.wd_valid;
                address      = cur_addr_q;
                data         = bus.wd_data;
                if (bus.wd_valid) begin
                    beat_d     = LW'(beat_q + LW'(1));
                    cur_addr_d = AW'(cur_addr_q + AW'(1));
                    if (last_beat) state_d = IDLE;
                end
            end
            READ: begin
                busy        = 1'b1;
                memR        = 1'b1;
                address     = cur_addr_q;
                resp_data_d = readData;
                state_d     = RESP;
            end
            RESP: begin
                busy           = 1'b1;
                bus.resp_valid = 1'b1;
                bus.resp_last  = last_beat;
                if (bus.resp_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d     = LW'(beat_q + LW'(1));
                        cur_addr_d = AW'(cur_addr_q + AW'(1));
                        state_d    = READ;
                    end
                end
            end
            ERR: begin
                busy    = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
